// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: core, auxiliary and memory-side signals of the data-bus arbiter.
// slave = arbiter view, master = environment view (masters plus data_memory).
interface data_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // core master
  logic                  c_req;
  logic [1:0]            c_mode;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_gnt;
  logic                  c_done;
  logic [DATA_WIDTH-1:0] c_rdata;
  logic                  c_err;
  // auxiliary master
  logic                  a_req;
  logic [1:0]            a_mode;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_done;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_err;
  // memory bus
  logic [1:0]            m_mode;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_ready;
  logic                  busy;

  modport slave (
    input  c_req, c_mode, c_addr, c_wdata,
    output c_gnt, c_done, c_rdata, c_err,
    input  a_req, a_mode, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata, a_err,
    output m_mode, m_addr, m_wdata,
    input  m_rdata, m_ready,
    output busy
  );

  modport master (
    output c_req, c_mode, c_addr, c_wdata,
    input  c_gnt, c_done, c_rdata, c_err,
    output a_req, a_mode, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata, a_err,
    input  m_mode, m_addr, m_wdata,
    output m_rdata, m_ready,
    input  busy
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter sharing the data_memory bus between the
// core and an auxiliary master. Define ARB_TIMEOUT_EN to build the ACCESS-state
// timeout abort (TIMEOUT_CYCLES); without it ACCESS waits for m_ready forever.
module data_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  data_bus_arbiter_if.slave bus
);

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic       OWN_CORE   = 1'b0;
  localparam logic       OWN_AUX    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Elaboration guard: the abort needs at least two ACCESS cycles to be meaningful.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("data_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;

  logic                  c_gnt_q, c_gnt_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  c_done_q, c_done_d;
  logic                  a_done_q, a_done_d;
  logic                  busy_q, busy_d;
  logic [1:0]            m_mode_q, m_mode_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;

  logic                  c_valid_c;
  logic                  a_valid_c;
  logic                  pick_aux_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_d;
  logic             c_err_q;
  logic             a_err_q;
`endif

  // Only reads and writes are real requests; modes 00 and 11 never win a grant.
  assign c_valid_c  = bus.c_req && ((bus.c_mode == MODE_READ) || (bus.c_mode == MODE_WRITE));
  assign a_valid_c  = bus.a_req && ((bus.a_mode == MODE_READ) || (bus.a_mode == MODE_WRITE));
  // Aux wins when it is alone, or on a tie when the core owned the bus last.
  assign pick_aux_c = a_valid_c && (!c_valid_c || (last_owner_q == OWN_CORE));

  // Next-state, latched transaction, rdata capture and registered-output images.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    c_rdata_d    = c_rdata_q;
    a_rdata_d    = a_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (c_valid_c || a_valid_c) begin
          state_d      = ST_ACCESS;
          owner_d      = pick_aux_c;
          last_owner_d = pick_aux_c;
          mode_d       = pick_aux_c ? bus.a_mode  : bus.c_mode;
          addr_d       = pick_aux_c ? bus.a_addr  : bus.c_addr;
          wdata_d      = pick_aux_c ? bus.a_wdata : bus.c_wdata;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_ACCESS: begin
        if (bus.m_ready) begin
          if (mode_q == MODE_READ) begin
            if (owner_q == OWN_AUX) a_rdata_d = bus.m_rdata;
            else                    c_rdata_d = bus.m_rdata;
          end
          state_d = ST_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered images of the state being entered.
    busy_d    = (state_d != ST_IDLE);
    c_gnt_d   = busy_d && (owner_d == OWN_CORE);
    a_gnt_d   = busy_d && (owner_d == OWN_AUX);
    c_done_d  = (state_d == ST_DONE) && (owner_d == OWN_CORE);
    a_done_d  = (state_d == ST_DONE) && (owner_d == OWN_AUX);
    m_mode_d  = (state_d == ST_ACCESS) ? mode_d  : MODE_NONE;
    m_addr_d  = (state_d == ST_ACCESS) ? addr_d  : '0;
    m_wdata_d = (state_d == ST_ACCESS) ? wdata_d : '0;
  end

  // State, transaction and output registers; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_AUX;
      mode_q       <= MODE_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      c_rdata_q    <= '0;
      a_rdata_q    <= '0;
      c_gnt_q      <= 1'b0;
      a_gnt_q      <= 1'b0;
      c_done_q     <= 1'b0;
      a_done_q     <= 1'b0;
      busy_q       <= 1'b0;
      m_mode_q     <= MODE_NONE;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      c_err_q      <= 1'b0;
      a_err_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      c_rdata_q    <= c_rdata_d;
      a_rdata_q    <= a_rdata_d;
      c_gnt_q      <= c_gnt_d;
      a_gnt_q      <= a_gnt_d;
      c_done_q     <= c_done_d;
      a_done_q     <= a_done_d;
      busy_q       <= busy_d;
      m_mode_q     <= m_mode_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      c_err_q      <= abort_d && (owner_q == OWN_CORE);
      a_err_q      <= abort_d && (owner_q == OWN_AUX);
`endif
    end
  end

  assign bus.c_gnt   = c_gnt_q;
  assign bus.a_gnt   = a_gnt_q;
  assign bus.c_done  = c_done_q;
  assign bus.a_done  = a_done_q;
  assign bus.c_rdata = c_rdata_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.m_mode  = m_mode_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.busy    = busy_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.c_err   = c_err_q;
  assign bus.a_err   = a_err_q;
`else
  assign bus.c_err   = 1'b0;
  assign bus.a_err   = 1'b0;
`endif

endmodule
